// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants and state encoding for the UART command decoder.
package uart_cmd_decoder_pkg;

    localparam logic [7:0] OPC_WR      = 8'hAA;
    localparam logic [7:0] OPC_RD      = 8'hBB;
    localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    localparam int unsigned OP_A_ADDR = 0;
    localparam int unsigned OP_B_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FN,
        ST_ALU_WAIT
    } cmd_state_e;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Parses UART command frames into register-file and ALU requests, with
// registered one-cycle strobes, wait-state timeout and ALU clock gating.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned FUN_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  PAR_ERR,
    input  logic                  STP_ERR,
    input  logic                  RD_DATA_VLD,
    input  logic                  ALU_OUT_VLD,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    output logic                  WR_EN,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  RD_EN,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic                  CMD_ERR
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    cmd_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  alu_en_q, alu_en_d;
    logic                  clk_gate_q, clk_gate_d;
    logic                  cmd_err_q, cmd_err_d;
    logic [15:0]           cnt_q, cnt_d;

    logic rx_ok, rx_bad, resp;

    assign rx_bad = RX_D_VLD & (PAR_ERR | STP_ERR);
    assign rx_ok  = RX_D_VLD & ~PAR_ERR & ~STP_ERR;
    assign resp   = (state_q == ST_RD_WAIT) ? RD_DATA_VLD : ALU_OUT_VLD;

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        cmd_err_d = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: if (rx_ok) begin
                if (RX_P_DATA == DATA_WIDTH'(OPC_WR))           state_d = ST_WR_ADDR;
                else if (RX_P_DATA == DATA_WIDTH'(OPC_RD))      state_d = ST_RD_ADDR;
                else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_OP))  state_d = ST_ALU_A;
                else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_NOP)) state_d = ST_ALU_FN;
                else                                            cmd_err_d = 1'b1;
            end
            ST_WR_ADDR: if (rx_ok) begin
                address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d   = ST_WR_DATA;
            end
            ST_WR_DATA: if (rx_ok) begin
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_RD_ADDR: if (rx_ok) begin
                address_d = RX_P_DATA[ADDR_WIDTH-1:0];
                rd_en_d   = 1'b1;
                cnt_d     = '0;
                state_d   = ST_RD_WAIT;
            end
            ST_ALU_A: if (rx_ok) begin
                address_d = ADDR_WIDTH'(OP_A_ADDR);
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = ST_ALU_B;
            end
            ST_ALU_B: if (rx_ok) begin
                address_d = ADDR_WIDTH'(OP_B_ADDR);
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = ST_ALU_FN;
            end
            ST_ALU_FN: if (rx_ok) begin
                alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                alu_en_d  = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ALU_WAIT;
            end
            ST_RD_WAIT, ST_ALU_WAIT: begin
                // Any byte seen while waiting is dropped and flagged; the response wins.
                cmd_err_d = RX_D_VLD;
                if (resp) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_bad) begin
            cmd_err_d = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    // Gate follows the ALU path, so every exit (result, abort, timeout) drops it.
    assign clk_gate_d = (state_d == ST_ALU_A) || (state_d == ST_ALU_B) ||
                        (state_d == ST_ALU_FN) || (state_d == ST_ALU_WAIT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            address_q  <= '0;
            wr_data_q  <= '0;
            alu_fun_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            alu_en_q   <= 1'b0;
            clk_gate_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            wr_data_q  <= wr_data_d;
            alu_fun_q  <= alu_fun_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            alu_en_q   <= alu_en_d;
            clk_gate_q <= clk_gate_d;
            cmd_err_q  <= cmd_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ADDRESS     = address_q;
    assign WR_DATA     = wr_data_q;
    assign ALU_FUN     = alu_fun_q;
    assign WR_EN       = wr_en_q;
    assign RD_EN       = rd_en_q;
    assign ALU_EN      = alu_en_q;
    assign CLK_GATE_EN = clk_gate_q;
    assign CMD_ERR     = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed frames plus random
// frames compared against a frame-level event model.
module tb_uart_cmd_decoder;

    localparam int unsigned TO = 10;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0, PAR_ERR = 1'b0, STP_ERR = 1'b0;
    logic       RD_DATA_VLD = 1'b0, ALU_OUT_VLD = 1'b0;
    logic [3:0] ADDRESS;
    logic       WR_EN, RD_EN, ALU_EN, CLK_GATE_EN, CMD_ERR;
    logic [7:0] WR_DATA;
    logic [3:0] ALU_FUN;

    uart_cmd_decoder #(
        .DATA_WIDTH    (8),
        .ADDR_WIDTH    (4),
        .FUN_WIDTH     (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .RD_DATA_VLD(RD_DATA_VLD),
        .ALU_OUT_VLD(ALU_OUT_VLD),
        .ADDRESS    (ADDRESS),
        .WR_EN      (WR_EN),
        .WR_DATA    (WR_DATA),
        .RD_EN      (RD_EN),
        .ALU_EN     (ALU_EN),
        .ALU_FUN    (ALU_FUN),
        .CLK_GATE_EN(CLK_GATE_EN),
        .CMD_ERR    (CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;

    localparam int EV_WR = 1, EV_RD = 2, EV_ALU = 3, EV_ERR = 4;

    logic [31:0] outs_w;
    assign outs_w = {11'b0, ADDRESS, WR_EN, WR_DATA, RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN, CMD_ERR};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int kind, input logic [7:0] a,
                                       input logic [7:0] d, input logic [7:0] f);
        return {8'(kind), a, d, f};
    endfunction

    // Output event monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (WR_EN)   obs_q.push_back(ev(EV_WR, 8'(ADDRESS), WR_DATA, 8'h00));
            if (RD_EN)   obs_q.push_back(ev(EV_RD, 8'(ADDRESS), 8'h00, 8'h00));
            if (ALU_EN)  obs_q.push_back(ev(EV_ALU, 8'h00, 8'h00, 8'(ALU_FUN)));
            if (CMD_ERR) obs_q.push_back(ev(EV_ERR, 8'h00, 8'h00, 8'h00));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        PAR_ERR   = pe;
        STP_ERR   = se;
        idle(1);
        RX_D_VLD  = 1'b0;
        PAR_ERR   = 1'b0;
        STP_ERR   = 1'b0;
    endtask

    task automatic pulse_resp(input bit is_alu);
        if (is_alu) ALU_OUT_VLD = 1'b1;
        else        RD_DATA_VLD = 1'b1;
        idle(1);
        ALU_OUT_VLD = 1'b0;
        RD_DATA_VLD = 1'b0;
    endtask

    task automatic compare_events(input string tag);
        int n;
        check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq(tag, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Random frame with optional byte error; expected events derived from frame semantics.
    task automatic run_random_frame();
        int         t, n, errpos, r;
        logic [7:0] b[4];
        bit         err_done;
        t = $urandom_range(0, 4);
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        case (t)
            0: begin b[0] = 8'hAA; n = 3; end
            1: begin b[0] = 8'hBB; n = 2; end
            2: begin b[0] = 8'hCC; n = 4; end
            3: begin b[0] = 8'hDD; n = 2; end
            default: begin
                n = 1;
                while (b[0] inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) b[0] = 8'($urandom);
            end
        endcase
        errpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
        err_done = 1'b0;
        for (int i = 0; i < n && !err_done; i++) begin
            idle($urandom_range(0, 2));
            if (i == errpos) begin
                r = $urandom_range(1, 3);
                send_byte(b[i], r[0], r[1]);
                err_done = 1'b1;
            end else begin
                send_byte(b[i], 1'b0, 1'b0);
            end
        end
        case (t)
            0: if (errpos < 0) exp_q.push_back(ev(EV_WR, b[1] & 8'h0F, b[2], 8'h00));
            1: if (errpos < 0) exp_q.push_back(ev(EV_RD, b[1] & 8'h0F, 8'h00, 8'h00));
            2: begin
                if (errpos < 0 || errpos >= 2) exp_q.push_back(ev(EV_WR, 8'h00, b[1], 8'h00));
                if (errpos < 0 || errpos >= 3) exp_q.push_back(ev(EV_WR, 8'h01, b[2], 8'h00));
                if (errpos < 0) exp_q.push_back(ev(EV_ALU, 8'h00, 8'h00, b[3] & 8'h0F));
            end
            3: if (errpos < 0) exp_q.push_back(ev(EV_ALU, 8'h00, 8'h00, b[1] & 8'h0F));
            default: ;
        endcase
        if (errpos >= 0 || t == 4) exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00, 8'h00));
        if (errpos < 0 && t >= 1 && t <= 3) begin
            idle($urandom_range(0, 5));
            pulse_resp(t != 1);
        end
        idle(1);
    endtask

    initial begin
        int lat;

        // Reset values
        idle(3);
        check_eq("reset_outs", outs_w, 32'h0);
        RST = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // Write command
        send_byte(8'hAA, 0, 0);
        send_byte(8'h05, 0, 0);
        send_byte(8'h3C, 0, 0);
        check_eq("wr_strobe", 32'(WR_EN), 32'h1);
        idle(1);
        check_eq("wr_pulse_len", 32'(WR_EN), 32'h0);
        check_eq("wr_data_hold", 32'(WR_DATA), 32'h3C);
        exp_q.push_back(ev(EV_WR, 8'h05, 8'h3C, 8'h00));
        idle(2);
        compare_events("t_write");

        // Read command with response 4 cycles later
        send_byte(8'hBB, 0, 0);
        send_byte(8'h07, 0, 0);
        check_eq("rd_strobe", 32'(RD_EN), 32'h1);
        idle(3);
        pulse_resp(1'b0);
        exp_q.push_back(ev(EV_RD, 8'h07, 8'h00, 8'h00));
        idle(1);
        compare_events("t_read");

        // Bytes during wait: dropped byte, then response colliding with a byte
        send_byte(8'hBB, 0, 0);
        send_byte(8'h02, 0, 0);
        idle(1);
        send_byte(8'h11, 0, 0);
        RD_DATA_VLD = 1'b1;
        send_byte(8'h77, 0, 0);
        RD_DATA_VLD = 1'b0;
        send_byte(8'hAA, 0, 0);
        send_byte(8'h04, 0, 0);
        send_byte(8'h09, 0, 0);
        exp_q.push_back(ev(EV_RD, 8'h02, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_WR, 8'h04, 8'h09, 8'h00));
        idle(2);
        compare_events("t_wait_bytes");

        // ALU operation with operands and clock gating
        send_byte(8'hCC, 0, 0);
        check_eq("gate_on_cc", 32'(CLK_GATE_EN), 32'h1);
        send_byte(8'h12, 0, 0);
        send_byte(8'h34, 0, 0);
        send_byte(8'h02, 0, 0);
        check_eq("alu_strobe", 32'(ALU_EN), 32'h1);
        check_eq("alu_fun", 32'(ALU_FUN), 32'h2);
        idle(2);
        check_eq("gate_in_wait", 32'(CLK_GATE_EN), 32'h1);
        pulse_resp(1'b1);
        check_eq("gate_off_resp", 32'(CLK_GATE_EN), 32'h0);
        exp_q.push_back(ev(EV_WR, 8'h00, 8'h12, 8'h00));
        exp_q.push_back(ev(EV_WR, 8'h01, 8'h34, 8'h00));
        exp_q.push_back(ev(EV_ALU, 8'h00, 8'h00, 8'h02));
        idle(1);
        compare_events("t_alu");

        // Parity error aborts a write; next NOP frame works
        send_byte(8'hAA, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h5A, 1, 0);
        send_byte(8'hDD, 0, 0);
        check_eq("gate_on_dd", 32'(CLK_GATE_EN), 32'h1);
        send_byte(8'h05, 0, 0);
        idle(1);
        pulse_resp(1'b1);
        exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_ALU, 8'h00, 8'h00, 8'h05));
        idle(1);
        compare_events("t_byte_err");

        // Timeout: CMD_ERR after TO wait cycles, gate drops; bad opcode
        send_byte(8'hDD, 0, 0);
        send_byte(8'h01, 0, 0);
        lat = 999;
        for (int k = 1; k <= 30; k++) begin
            idle(1);
            if (CMD_ERR) begin
                lat = k;
                break;
            end
        end
        check_eq("timeout_latency", 32'(lat), 32'(TO));
        check_eq("gate_off_timeout", 32'(CLK_GATE_EN), 32'h0);
        send_byte(8'h55, 0, 0);
        exp_q.push_back(ev(EV_ALU, 8'h00, 8'h00, 8'h01));
        exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00, 8'h00));
        exp_q.push_back(ev(EV_ERR, 8'h00, 8'h00, 8'h00));
        idle(2);
        compare_events("t_timeout");

        // Asynchronous reset in ALU_B, then a clean write
        send_byte(8'hCC, 0, 0);
        send_byte(8'h12, 0, 0);
        idle(1);
        #1 RST = 1'b0;
        #1 check_eq("async_reset", outs_w, 32'h0);
        idle(2);
        RST = 1'b1;
        idle(1);
        send_byte(8'hAA, 0, 0);
        send_byte(8'h01, 0, 0);
        send_byte(8'hFF, 0, 0);
        exp_q.push_back(ev(EV_WR, 8'h00, 8'h12, 8'h00));
        exp_q.push_back(ev(EV_WR, 8'h01, 8'hFF, 8'h00));
        idle(2);
        compare_events("t_reset");

        // Random frames
        repeat (60) run_random_frame();
        idle(2);
        compare_events("t_random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Consumes received bytes from the UART receiver (parallel data, valid pulse, parity/framing flags) in the system clock domain.
- Parses multi-byte command frames and issues register-file write/read requests and ALU operation requests.
- Gates the ALU clock only while an ALU command is active.
- Sits between the RX data synchronizer and the register file/ALU. Response forwarding to the TX path is a separate block.

Parameters:
- DATA_WIDTH, 8, width of received byte and register data.
- ADDR_WIDTH, 4, register-file address width; address taken from low ADDR_WIDTH bits of the address byte.
- FUN_WIDTH, 4, ALU function width; taken from low FUN_WIDTH bits of the function byte.
- TIMEOUT_CYCLES, 255, maximum cycles spent in a wait state before abort; range 1..2^16-1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte, valid only with RX_D_VLD.
- RX_D_VLD  in  1  one-cycle pulse per received byte, already synchronized to CLK.
- PAR_ERR  in  1  parity error for current byte, sampled with RX_D_VLD.
- STP_ERR  in  1  framing error for current byte, sampled with RX_D_VLD.
- RD_DATA_VLD  in  1  register file read-data valid.
- ALU_OUT_VLD  in  1  ALU result valid.
- ADDRESS  out  ADDR_WIDTH  register-file address.
- WR_EN  out  1  register write strobe.
- WR_DATA  out  DATA_WIDTH  register write data.
- RD_EN  out  1  register read strobe.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  FUN_WIDTH  ALU function.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- CMD_ERR  out  1  one-cycle error pulse.

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; timeout counter 0.
- All outputs are registered. A strobe rises the cycle after the qualifying RX_D_VLD and lasts exactly 1 cycle.
- Opcodes, checked in IDLE only: WR=0xAA, RD=0xBB, ALU_OP=0xCC, ALU_NOP=0xDD.
- Transitions: each "on byte" step advances when RX_D_VLD=1 and the byte has no error.
  - IDLE on 0xAA -> WR_ADDR.
  - IDLE on 0xBB -> RD_ADDR.
  - IDLE on 0xCC -> ALU_A.
  - IDLE on 0xDD -> ALU_FN.
  - IDLE on any other byte: CMD_ERR pulse, stay IDLE.
- WR_ADDR: latch ADDRESS, -> WR_DATA.
- WR_DATA: WR_DATA=byte, WR_EN pulse, -> IDLE.
- RD_ADDR: latch ADDRESS, RD_EN pulse, -> RD_WAIT.
- RD_WAIT: RD_DATA_VLD=1 -> IDLE.
- ALU_A: ADDRESS=0, WR_DATA=byte, WR_EN pulse, -> ALU_B.
- ALU_B: ADDRESS=1, WR_DATA=byte, WR_EN pulse, -> ALU_FN.
- ALU_FN: latch ALU_FUN, ALU_EN pulse, -> ALU_WAIT.
- ALU_WAIT: ALU_OUT_VLD=1 -> IDLE.
- CLK_GATE_EN: set in the cycle after accepting 0xCC or 0xDD; cleared the cycle after ALU_OUT_VLD, or on any abort out of the ALU path.
- Byte error: RX_D_VLD with PAR_ERR or STP_ERR in any state -> CMD_ERR pulse, -> IDLE, no strobe issued for that byte. Already-issued writes are not undone.
- Bytes arriving in RD_WAIT/ALU_WAIT: dropped, CMD_ERR pulse, state unchanged.
- Response and byte in the same cycle: the response wins (-> IDLE); the byte is dropped and CMD_ERR pulses.
- Timeout: counter clears on entry to RD_WAIT/ALU_WAIT and increments each wait cycle. Reaching TIMEOUT_CYCLES -> CMD_ERR, -> IDLE. Mid-frame parsing states have no timeout.
- ADDRESS, WR_DATA, ALU_FUN hold their last value between strobes.
- Reset asserted mid-frame aborts immediately; no partial strobe is emitted.

Decomposition:
- Shared package holds:
  - opcode constants (0xAA/0xBB/0xCC/0xDD);
  - operand addresses OP_A_ADDR=0, OP_B_ADDR=1;
  - state enumeration.
- Single module. The timeout counter is inline; no sub-module is warranted.

Test Plan:
- Bytes AA,05,3C -> one WR_EN pulse with ADDRESS=5, WR_DATA=0x3C; then IDLE, CMD_ERR never asserted.
- Bytes BB,07, then RD_DATA_VLD 4 cycles later -> RD_EN pulse with ADDRESS=7; IDLE after RD_DATA_VLD.
- Bytes CC,12,34,02, then ALU_OUT_VLD -> WR_EN at addr0=0x12, then WR_EN at addr1=0x34, then ALU_EN with ALU_FUN=2. CLK_GATE_EN high from after CC until the cycle after ALU_OUT_VLD.
- Bytes AA,03 then a byte with PAR_ERR=1 -> no WR_EN, CMD_ERR pulse, IDLE. A following DD,05 executes normally.
- Bytes DD,01 with ALU_OUT_VLD withheld and TIMEOUT_CYCLES=10 -> CMD_ERR after 10 wait cycles, CLK_GATE_EN drops. Byte 0x55 in IDLE -> CMD_ERR, no strobes.
- RST pulled low during ALU_B -> all outputs 0 asynchronously; after release, WR command AA,01,FF executes correctly.
